// File: rtl/clkgate_ctrl_pkg.sv
// Shared definitions for the clock-gate controller: FSM state encoding.
package clkgate_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HOLD  = 2'd1,
    ST_GATED = 2'd2,
    ST_WAKE  = 2'd3
  } state_e;

endpackage

// File: rtl/cell_clkgate_low.sv
// Latch-based clock gate: the enable is captured while clk_in is low, so the
// output can only start or stop on a full high phase and never glitches.
module cell_clkgate_low (
  input  logic clk_in,
  input  logic enable,
  output logic clk_out
);

  logic en_l;

  always_latch begin
    if (!clk_in) en_l <= enable;
  end

  assign clk_out = clk_in & en_l;

endmodule

// File: rtl/clkgate_ctrl.sv
// Idle-timeout clock-gate controller with per-requester acknowledge.
// Define CLKGATE_CTRL_STATS_EN to build the gated-cycle statistics counter.
module clkgate_ctrl
  import clkgate_ctrl_pkg::*;
#(
  parameter int N_REQ     = 2,
  parameter int TIMEOUT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req,
  output logic [N_REQ-1:0]     ack,
  input  logic                 force_on,
  input  logic [TIMEOUT_W-1:0] idle_timeout,
  output logic                 clk_gated,
  output logic                 clk_active,
  output logic [31:0]          gated_cycles
);

  state_e               state_q, state_d;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic                 en_q, en_d;
  logic                 demand;

  assign demand = (|req) | force_on;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
      en_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
    end
  end

  // The idle timeout is only sampled on RUN->HOLD; HOLD counts down its own copy.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_RUN: begin
        if (!demand) begin
          if (idle_timeout == '0) begin
            state_d = ST_GATED;
          end else begin
            cnt_d   = idle_timeout;
            state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (demand)                          state_d = ST_RUN;
        else if (cnt_q == TIMEOUT_W'(1))     state_d = ST_GATED;
        else                                 cnt_d   = cnt_q - TIMEOUT_W'(1);
      end
      ST_GATED: begin
        if (demand) state_d = ST_WAKE;
      end
      ST_WAKE: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
    en_d = (state_d != ST_GATED);
  end

  // WAKE is excluded so ack only rises once the gated clock has a full cycle behind it.
  assign ack = (!rst && (state_q == ST_RUN || state_q == ST_HOLD)) ? req : '0;

  assign clk_active = en_q;

  cell_clkgate_low u_cg (
    .clk_in  (clk),
    .enable  (en_q),
    .clk_out (clk_gated)
  );

`ifdef CLKGATE_CTRL_STATS_EN
  logic [31:0] gated_cycles_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      gated_cycles_q <= '0;
    else if (state_q == ST_GATED) gated_cycles_q <= gated_cycles_q + 32'd1;
  end

  assign gated_cycles = gated_cycles_q;
`else
  assign gated_cycles = '0;
`endif

endmodule

// File: tb/tb_clkgate_ctrl.sv
// Self-checking bench for clkgate_ctrl against an idle-streak reference model.
// Honours CLKGATE_CTRL_STATS_EN for the expected gated_cycles value.
module tb_clkgate_ctrl;

`ifdef CLKGATE_CTRL_STATS_EN
  localparam bit STATS_EN = 1'b1;
`else
  localparam bit STATS_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req;
  logic [1:0]  ack;
  logic        force_on;
  logic [7:0]  idle_timeout;
  logic        clk_gated;
  logic        clk_active;
  logic [31:0] gated_cycles;

  int vectors     = 0;
  int miscompares = 0;
  int pulseCount  = 0;

  // Reference model: gated / waking flags plus the length of the current idle streak.
  bit          mGated, mWaking;
  int          mIdle, mT;
  logic [31:0] mGc;

  clkgate_ctrl #(.N_REQ(2), .TIMEOUT_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .ack          (ack),
    .force_on     (force_on),
    .idle_timeout (idle_timeout),
    .clk_gated    (clk_gated),
    .clk_active   (clk_active),
    .gated_cycles (gated_cycles)
  );

  always #5 clk = ~clk;

  always @(posedge clk_gated) pulseCount++;

  task automatic modelReset();
    mGated = 0; mWaking = 0; mIdle = 0; mT = 0; mGc = '0;
  endtask

  task automatic modelEdge(input logic [1:0] r, input logic f, input logic [7:0] t);
    bit active;
    active = (r != 2'b00) || f;
    if (rst) begin
      modelReset();
      return;
    end
    if (mGated && STATS_EN) mGc = mGc + 32'd1;
    if (mGated) begin
      if (active) begin mGated = 0; mWaking = 1; end
    end else if (mWaking) begin
      mWaking = 0; mIdle = 0;
    end else if (active) begin
      mIdle = 0;
    end else begin
      if (mIdle == 0) mT = int'(t);
      mIdle++;
      if (mIdle == mT + 1) begin mGated = 1; mIdle = 0; end
    end
  endtask

  function automatic logic [1:0] expAck();
    return (rst || mGated || mWaking) ? 2'b00 : req;
  endfunction

  task automatic setIn(input logic [1:0] r, input logic f, input logic [7:0] t);
    req = r; force_on = f; idle_timeout = t;
    #1;
  endtask

  task automatic advance();
    @(posedge clk);
    modelEdge(req, force_on, idle_timeout);
    @(negedge clk);
  endtask

  task automatic test_reset();
    int p0;
    rst = 1'b1;
    setIn(2'b11, 1'b0, 8'd3);
    vectors++;
    if (ack !== 2'b00) begin miscompares++; $display("[TB] FAIL reset_ack: got %b want 00", ack); end
    vectors++;
    if (clk_active !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_en: got %b want 1", clk_active); end
    vectors++;
    if (gated_cycles !== 32'd0) begin miscompares++; $display("[TB] FAIL reset_stats: got %0d want 0", gated_cycles); end
    p0 = pulseCount;
    repeat (3) advance();
    vectors++;
    if (pulseCount - p0 !== 3) begin miscompares++; $display("[TB] FAIL reset_pulses: got %0d want 3", pulseCount - p0); end
    setIn(2'b00, 1'b0, 8'd3);
  endtask

  task automatic test_idle_to_gated();
    int p0;
    rst = 1'b0;
    modelReset();
    p0 = pulseCount;
    for (int i = 0; i < 6; i++) begin
      setIn(2'b00, 1'b0, 8'd3);
      vectors++;
      if (ack !== expAck()) begin miscompares++; $display("[TB] FAIL idle_ack: got %b want %b", ack, expAck()); end
      advance();
      vectors++;
      if (clk_active !== !mGated) begin miscompares++; $display("[TB] FAIL idle_en cyc %0d: got %b want %b", i, clk_active, !mGated); end
    end
    vectors++;
    if (pulseCount - p0 !== 4) begin miscompares++; $display("[TB] FAIL idle_pulses: got %0d want 4", pulseCount - p0); end
    vectors++;
    if (clk_active !== 1'b0) begin miscompares++; $display("[TB] FAIL idle_gated: got %b want 0", clk_active); end
  endtask

  task automatic test_wake();
    for (int i = 0; i < 6; i++) begin
      setIn((i == 0) ? 2'b10 : 2'b00, 1'b0, 8'd3);
      vectors++;
      if (ack !== 2'b00) begin miscompares++; $display("[TB] FAIL wake_ack cyc %0d: got %b want 00", i, ack); end
      advance();
      vectors++;
      if (clk_active !== !mGated) begin miscompares++; $display("[TB] FAIL wake_en cyc %0d: got %b want %b", i, clk_active, !mGated); end
      if (i == 0) begin
        vectors++;
        if (clk_active !== 1'b1) begin miscompares++; $display("[TB] FAIL wake_first: got %b want 1", clk_active); end
      end
    end
    vectors++;
    if (clk_active !== 1'b0) begin miscompares++; $display("[TB] FAIL wake_regate: got %b want 0", clk_active); end
  endtask

  task automatic test_hold_race();
    logic [1:0] r;
    for (int i = 0; i < 9; i++) begin
      r = (i < 2 || i >= 7) ? 2'b01 : 2'b00;
      setIn(r, 1'b0, 8'd5);
      vectors++;
      if (ack !== expAck()) begin miscompares++; $display("[TB] FAIL race_ack cyc %0d: got %b want %b", i, ack, expAck()); end
      if (i == 7) begin
        vectors++;
        if (ack !== 2'b01) begin miscompares++; $display("[TB] FAIL race_same_cycle_ack: got %b want 01", ack); end
      end
      advance();
      vectors++;
      if (clk_active !== !mGated) begin miscompares++; $display("[TB] FAIL race_en cyc %0d: got %b want %b", i, clk_active, !mGated); end
    end
    setIn(2'b01, 1'b0, 8'd5);
    vectors++;
    if (ack !== 2'b01) begin miscompares++; $display("[TB] FAIL race_run_after: got %b want 01", ack); end
  endtask

  task automatic test_toggle();
    for (int i = 0; i < 24; i++) begin
      setIn(i[0] ? 2'b10 : 2'b00, 1'b0, 8'd0);
      vectors++;
      if (ack !== expAck()) begin miscompares++; $display("[TB] FAIL toggle_ack cyc %0d: got %b want %b", i, ack, expAck()); end
      advance();
      vectors++;
      if (clk_active !== !mGated) begin miscompares++; $display("[TB] FAIL toggle_en cyc %0d: got %b want %b", i, clk_active, !mGated); end
      vectors++;
      if (gated_cycles !== mGc) begin miscompares++; $display("[TB] FAIL toggle_stats cyc %0d: got %0d want %0d", i, gated_cycles, mGc); end
    end
  endtask

  task automatic test_force_on();
    logic [31:0] gcStart;
    repeat (2) begin setIn(2'b00, 1'b1, 8'd2); advance(); end
    gcStart = mGc;
    for (int i = 0; i < 1000; i++) begin
      setIn(2'b00, 1'b1, 8'($urandom_range(0, 4)));
      vectors++;
      if (ack !== 2'b00) begin miscompares++; $display("[TB] FAIL force_ack cyc %0d: got %b want 00", i, ack); end
      advance();
      vectors++;
      if (clk_active !== 1'b1) begin miscompares++; $display("[TB] FAIL force_en cyc %0d: got %b want 1", i, clk_active); end
    end
    vectors++;
    if (gated_cycles !== gcStart) begin miscompares++; $display("[TB] FAIL force_stats: got %0d want %0d", gated_cycles, gcStart); end
  endtask

  task automatic test_random();
    logic [1:0] r;
    logic       f;
    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      f = ($urandom_range(0, 40) == 0);
      setIn(r, f, 8'($urandom_range(0, 4)));
      vectors++;
      if (ack !== expAck()) begin miscompares++; $display("[TB] FAIL rand_ack cyc %0d: got %b want %b", i, ack, expAck()); end
      advance();
      vectors++;
      if (clk_active !== !mGated) begin miscompares++; $display("[TB] FAIL rand_en cyc %0d: got %b want %b", i, clk_active, !mGated); end
      vectors++;
      if (gated_cycles !== mGc) begin miscompares++; $display("[TB] FAIL rand_stats cyc %0d: got %0d want %0d", i, gated_cycles, mGc); end
    end
  endtask

  task automatic test_stats_reset();
    int p0;
    rst = 1'b1;
    setIn(2'b00, 1'b0, 8'd0);
    advance();
    rst = 1'b0;
    modelReset();
    for (int i = 0; i < 11; i++) begin
      setIn(2'b00, 1'b0, 8'd0);
      advance();
    end
    vectors++;
    if (gated_cycles !== (STATS_EN ? 32'd10 : 32'd0)) begin
      miscompares++; $display("[TB] FAIL stats_count: got %0d want %0d", gated_cycles, STATS_EN ? 10 : 0);
    end
    vectors++;
    if (clk_active !== 1'b0) begin miscompares++; $display("[TB] FAIL stats_gated: got %b want 0", clk_active); end
    #3 rst = 1'b1;
    #1;
    vectors++;
    if (clk_active !== 1'b1) begin miscompares++; $display("[TB] FAIL async_en: got %b want 1", clk_active); end
    vectors++;
    if (gated_cycles !== 32'd0) begin miscompares++; $display("[TB] FAIL async_stats: got %0d want 0", gated_cycles); end
    p0 = pulseCount;
    @(posedge clk);
    #1;
    vectors++;
    if (pulseCount - p0 !== 1) begin miscompares++; $display("[TB] FAIL async_pulse: got %0d want 1", pulseCount - p0); end
    @(negedge clk);
    rst = 1'b0;
    modelReset();
  endtask

  initial begin
    rst = 1'b1; req = 2'b00; force_on = 1'b0; idle_timeout = 8'd3;
    modelReset();
    @(negedge clk);
    test_reset();
    test_idle_to_gated();
    test_wake();
    test_hold_race();
    test_toggle();
    test_force_on();
    test_random();
    test_stats_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
